// File: rtl/sparhixcel_pkg.sv
// sparhixcel_pkg: shared weight-path types and constants.
package sparhixcel_pkg;
    localparam int N_ROWS_ARRAY = 16;
    localparam int F_WIDTH      = 8;
    localparam int WORD_WIDTH   = N_ROWS_ARRAY * F_WIDTH;

    typedef logic [WORD_WIDTH-1:0] weight_word_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_ACTIVE  = 2'd3
    } bank_state_e;
endpackage

// File: rtl/weight_pingpong_buffer_if.sv
// weight_pingpong_buffer_if: write-fill and array-read signals of the weight staging bank.
interface weight_pingpong_buffer_if;
    import sparhixcel_pkg::*;

    logic         wr_valid_i;
    logic         wr_ready_o;
    weight_word_t wr_data_i;
    logic         wr_last_i;
    logic         rd_ld_i;
    logic         rd_repeat_i;
    logic         rd_release_i;
    logic         rd_valid_o;
    weight_word_t f_weight_o;
    logic         tile_last_o;
    logic [3:0]   bank_state_o;
    logic         underrun_o;

    modport slave (
        input  wr_valid_i, wr_data_i, wr_last_i, rd_ld_i, rd_repeat_i, rd_release_i,
        output wr_ready_o, rd_valid_o, f_weight_o, tile_last_o, bank_state_o, underrun_o
    );

    modport master (
        output wr_valid_i, wr_data_i, wr_last_i, rd_ld_i, rd_repeat_i, rd_release_i,
        input  wr_ready_o, rd_valid_o, f_weight_o, tile_last_o, bank_state_o, underrun_o
    );
endinterface

// File: rtl/weight_bank.sv
// weight_bank: DEPTH-word weight storage, registered write, combinational indexed read.
module weight_bank
    import sparhixcel_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wr_idx_i,
    input  weight_word_t  wr_data_i,
    input  logic [AW-1:0] rd_idx_i,
    output weight_word_t  rd_data_o
);
    weight_word_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wr_idx_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/weight_pingpong_buffer.sv
// weight_pingpong_buffer: two-bank weight staging; one bank fills while the array reads the other.
module weight_pingpong_buffer
    import sparhixcel_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int IDX_WIDTH = $clog2(DEPTH + 1)
) (
    input logic                      clk_i,
    input logic                      rd_weight_rst,
    weight_pingpong_buffer_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);
    localparam logic [IDX_WIDTH-1:0] ONE      = IDX_WIDTH'(1);

    bank_state_e          st_q [2];
    bank_state_e          st_d [2];
    logic [IDX_WIDTH-1:0] len_q [2];
    logic [IDX_WIDTH-1:0] len_d [2];
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [IDX_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
    weight_word_t         f_weight_q, f_weight_d;
    logic                 tile_last_q, tile_last_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 underrun_q, underrun_d;
    weight_word_t         rd_word [2];

    logic wr_ready, wr_fire, wr_done, rd_act, rd_end, rd_drop;

    assign wr_ready = (st_q[wr_bank_q] == BANK_EMPTY) || (st_q[wr_bank_q] == BANK_FILLING);
    assign wr_fire  = bus.wr_valid_i && wr_ready;
    assign wr_done  = wr_fire && (bus.wr_last_i || wr_idx_q == LAST_IDX);
    // rd_bank always tracks the ACTIVE bank whenever one exists
    assign rd_act   = st_q[rd_bank_q] == BANK_ACTIVE;
    assign rd_end   = rd_idx_q == len_q[rd_bank_q] - ONE;
    assign rd_drop  = rd_act && (bus.rd_release_i || (bus.rd_ld_i && rd_end && !bus.rd_repeat_i));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        weight_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk_i     (clk_i),
            .we_i      (wr_fire && wr_bank_q == 1'(b)),
            .wr_idx_i  (wr_idx_q[AW-1:0]),
            .wr_data_i (bus.wr_data_i),
            .rd_idx_i  (rd_idx_q[AW-1:0]),
            .rd_data_o (rd_word[b])
        );
    end

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            st_q        <= '{BANK_EMPTY, BANK_EMPTY};
            len_q       <= '{'0, '0};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            f_weight_q  <= '0;
            tile_last_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            len_q       <= len_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            f_weight_q  <= f_weight_d;
            tile_last_q <= tile_last_d;
            rd_valid_q  <= rd_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        if (wr_fire) begin
            st_d[wr_bank_q] = wr_done ? BANK_FULL : BANK_FILLING;
            wr_idx_d        = wr_done ? '0 : wr_idx_q + ONE;
            wr_bank_d       = wr_bank_q ^ wr_done;
            if (wr_done) len_d[wr_bank_q] = wr_idx_q + ONE;
        end
        // a tile completing this cycle in the other bank is picked up by the gapless swap
        if (rd_drop) begin
            st_d[rd_bank_q]  = BANK_EMPTY;
            st_d[!rd_bank_q] = (st_d[!rd_bank_q] == BANK_FULL) ? BANK_ACTIVE : st_d[!rd_bank_q];
            rd_bank_d        = !rd_bank_q;
            rd_idx_d         = '0;
        end else if (rd_act) begin
            rd_idx_d = !bus.rd_ld_i ? rd_idx_q : rd_end ? '0 : rd_idx_q + ONE;
        end else if (st_q[rd_bank_q] == BANK_FULL) begin
            st_d[rd_bank_q] = BANK_ACTIVE;
            rd_idx_d        = '0;
        end else if (st_q[!rd_bank_q] == BANK_FULL) begin
            st_d[!rd_bank_q] = BANK_ACTIVE;
            rd_bank_d        = !rd_bank_q;
            rd_idx_d         = '0;
        end
    end

    always_comb begin
        f_weight_d  = (bus.rd_ld_i && rd_act) ? rd_word[rd_bank_q] : f_weight_q;
        tile_last_d = (bus.rd_ld_i && rd_act) ? rd_end : tile_last_q;
        underrun_d  = underrun_q || (bus.rd_ld_i && !rd_act);
        rd_valid_d  = (st_d[0] == BANK_ACTIVE) || (st_d[1] == BANK_ACTIVE);
    end

    assign bus.wr_ready_o   = wr_ready;
    assign bus.rd_valid_o   = rd_valid_q;
    assign bus.f_weight_o   = f_weight_q;
    assign bus.tile_last_o  = tile_last_q;
    assign bus.bank_state_o = {st_q[1], st_q[0]};
    assign bus.underrun_o   = underrun_q;
endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb_weight_pingpong_buffer: directed fill/read/swap/repeat/underrun/reset scenarios with a read scoreboard.
module tb_weight_pingpong_buffer;
    import sparhixcel_pkg::*;

    localparam int WW = WORD_WIDTH + 1;

    logic clk_i = 1'b0;
    logic rd_weight_rst = 1'b1;
    always #5 clk_i = ~clk_i;

    weight_pingpong_buffer_if bus ();

    weight_pingpong_buffer dut (
        .clk_i         (clk_i),
        .rd_weight_rst (rd_weight_rst),
        .bus           (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [WW-1:0] sb_q [$];

    function automatic weight_word_t w(input logic [7:0] k);
        return {N_ROWS_ARRAY{k}};
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic st(input logic [3:0] e_state, input logic e_valid);
        chk("bank_state", WW'(bus.bank_state_o), WW'(e_state));
        chk("rd_valid", WW'(bus.rd_valid_o), WW'(e_valid));
    endtask

    task automatic wr(input logic [7:0] k, input logic last);
        chk("wr_ready", WW'(bus.wr_ready_o), WW'(1));
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = w(k);
        bus.wr_last_i  = last;
        tick;
        bus.wr_valid_i = 1'b0;
        bus.wr_last_i  = 1'b0;
    endtask

    task automatic ld(input logic [7:0] k, input logic last, input logic rel);
        logic [WW-1:0] e;
        sb_q.push_back({last, w(k)});
        bus.rd_ld_i      = 1'b1;
        bus.rd_release_i = rel;
        tick;
        bus.rd_ld_i      = 1'b0;
        bus.rd_release_i = 1'b0;
        e = sb_q.pop_front();
        chk("f_weight", {bus.tile_last_o, bus.f_weight_o}, e);
    endtask

    task automatic zeros(input string tag);
        chk({tag, "_fw"}, {bus.tile_last_o, bus.f_weight_o}, '0);
        chk({tag, "_st"}, WW'(bus.bank_state_o), '0);
        chk({tag, "_valid"}, WW'(bus.rd_valid_o), '0);
        chk({tag, "_underrun"}, WW'(bus.underrun_o), '0);
    endtask

    initial begin
        bus.wr_valid_i   = 1'b0;
        bus.wr_data_i    = '0;
        bus.wr_last_i    = 1'b0;
        bus.rd_ld_i      = 1'b0;
        bus.rd_repeat_i  = 1'b0;
        bus.rd_release_i = 1'b0;
        repeat (2) @(negedge clk_i);
        zeros("reset");
        rd_weight_rst = 1'b0;
        // first tile, explicit last
        wr(8'h01, 1'b0);
        st(4'b0001, 1'b0);
        wr(8'h02, 1'b0);
        wr(8'h03, 1'b1);
        st(4'b0010, 1'b0);
        tick;
        st(4'b0011, 1'b1);
        chk("wr_ready_bank1", WW'(bus.wr_ready_o), WW'(1));
        ld(8'h01, 1'b0, 1'b0);
        ld(8'h02, 1'b0, 1'b0);
        ld(8'h03, 1'b1, 1'b0);
        st(4'b0000, 1'b0);
        // both banks loaded, implicit last, gapless swap
        wr(8'h11, 1'b0);
        wr(8'h12, 1'b1);
        st(4'b1000, 1'b0);
        wr(8'h21, 1'b0);
        st(4'b1101, 1'b1);
        wr(8'h22, 1'b0);
        wr(8'h23, 1'b0);
        wr(8'h24, 1'b0);
        st(4'b1110, 1'b1);
        chk("wr_ready_full", WW'(bus.wr_ready_o), WW'(0));
        ld(8'h11, 1'b0, 1'b0);
        ld(8'h12, 1'b1, 1'b0);
        st(4'b0011, 1'b1);
        chk("wr_ready_swap", WW'(bus.wr_ready_o), WW'(1));
        ld(8'h21, 1'b0, 1'b0);
        ld(8'h22, 1'b0, 1'b0);
        ld(8'h23, 1'b0, 1'b0);
        ld(8'h24, 1'b1, 1'b0);
        st(4'b0000, 1'b0);
        // weight-stationary repeat
        wr(8'h31, 1'b0);
        wr(8'h32, 1'b1);
        st(4'b1000, 1'b0);
        tick;
        st(4'b1100, 1'b1);
        bus.rd_repeat_i = 1'b1;
        ld(8'h31, 1'b0, 1'b0);
        ld(8'h32, 1'b1, 1'b0);
        ld(8'h31, 1'b0, 1'b0);
        ld(8'h32, 1'b1, 1'b0);
        ld(8'h31, 1'b0, 1'b0);
        st(4'b1100, 1'b1);
        bus.rd_repeat_i = 1'b0;
        // write completion into bank0 together with release of bank1
        bus.wr_valid_i   = 1'b1;
        bus.wr_data_i    = w(8'h41);
        bus.wr_last_i    = 1'b1;
        bus.rd_release_i = 1'b1;
        tick;
        bus.wr_valid_i   = 1'b0;
        bus.wr_last_i    = 1'b0;
        bus.rd_release_i = 1'b0;
        st(4'b0011, 1'b1);
        chk("hold_on_release", {bus.tile_last_o, bus.f_weight_o}, {1'b0, w(8'h31)});
        ld(8'h41, 1'b1, 1'b0);
        st(4'b0000, 1'b0);
        // release alongside a load: output still loads, bank drops
        wr(8'h51, 1'b0);
        wr(8'h52, 1'b1);
        st(4'b1000, 1'b0);
        tick;
        st(4'b1100, 1'b1);
        ld(8'h51, 1'b0, 1'b1);
        st(4'b0000, 1'b0);
        // underrun
        chk("underrun_pre", WW'(bus.underrun_o), WW'(0));
        bus.rd_ld_i = 1'b1;
        tick;
        bus.rd_ld_i = 1'b0;
        chk("underrun_set", WW'(bus.underrun_o), WW'(1));
        chk("underrun_hold_fw", {bus.tile_last_o, bus.f_weight_o}, {1'b0, w(8'h51)});
        repeat (3) tick;
        chk("underrun_sticky", WW'(bus.underrun_o), WW'(1));
        // asynchronous reset mid-fill
        wr(8'h61, 1'b0);
        wr(8'h62, 1'b0);
        st(4'b0001, 1'b0);
        #2 rd_weight_rst = 1'b1;
        #1 zeros("rst_fill");
        @(negedge clk_i) rd_weight_rst = 1'b0;
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        wr(8'h03, 1'b1);
        st(4'b0010, 1'b0);
        tick;
        st(4'b0011, 1'b1);
        ld(8'h01, 1'b0, 1'b0);
        // asynchronous reset mid-read
        #2 rd_weight_rst = 1'b1;
        #1 zeros("rst_read");
        @(negedge clk_i) rd_weight_rst = 1'b0;
        wr(8'h71, 1'b0);
        wr(8'h72, 1'b1);
        st(4'b0010, 1'b0);
        tick;
        st(4'b0011, 1'b1);
        ld(8'h71, 1'b0, 1'b0);
        ld(8'h72, 1'b1, 1'b0);
        st(4'b0000, 1'b0);
        chk("scoreboard_empty", WW'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
